pixel_window_col: RTL
=====================

# pixel_window_col

Streaming column generator for the ORB feature front end. It accepts one raster-order pixel per enabled cycle and keeps ROWS-1 previous image lines in internal circular line memories. Each enabled cycle it emits the vertical column of ROWS pixels at the current x position. It sits between the pixel source and the FAST/BRIEF window shift stages, which assemble ROWS x ROWS patches from successive columns.

## Interface
- WIDTH, 8, pixel bit width
- IMG_W, 640, pixels per line (line memory depth)
- IMG_H, 480, lines per frame
- ROWS, 7, window height (column length), >= 2
- CW, 10, counter width; 2^CW >= max(IMG_W, IMG_H)
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  dat_in valid this cycle; the pixel is consumed
- dat_in  in  WIDTH  pixel, raster order
- col_out  out  ROWS*WIDTH  column; slice [WIDTH-1:0] = current line, slice k = line y-k
- col_val  out  1  col_out updated this cycle
- win_val  out  1  col_val and a full ROWS x ROWS window ends at this column
- col_x  out  CW  x of the column presented
- row_y  out  CW  y of the column presented

## Operation
- Internal x_cnt (0..IMG_W-1) and y_cnt (0..IMG_H-1) give the position of the incoming pixel.
- Line memories: ROWS-1 arrays of IMG_W words, lbuf[1..ROWS-1], all addressed by x_cnt.
- On an ena cycle:
  - read lbuf[k][x_cnt] for all k;
  - write dat_in to lbuf[1][x_cnt];
  - write the old lbuf[k-1][x_cnt] value to lbuf[k][x_cnt] for k>=2 (vertical cascade, read-before-write on the same address).
- Output register, loaded on ena:
  - slice 0 = dat_in; slice k = old lbuf[k][x_cnt];
  - slice k is forced to 0 when y_cnt < k, so lines not yet written in this frame read as zero and memory is never reset.
- Counters:
  - x_cnt increments on ena and wraps IMG_W-1 -> 0; y_cnt increments on that wrap.
  - y_cnt wraps IMG_H-1 -> 0 at the last pixel of the frame; zero-gating then restarts with the new frame.
- win_val = ena-registered, and (y_cnt >= ROWS-1) and (x_cnt >= ROWS-1) at capture.
- ena low: no writes, no counter change; col_out, col_x and row_y hold; col_val = win_val = 0.

## Timing
- Latency: 1 cycle, from an ena edge to col_val/col_out/col_x/row_y.
- Throughput: one pixel per cycle; ena may be held high indefinitely with no bubbles.
- Reset values, asserted asynchronously:
  - x_cnt = y_cnt = 0;
  - col_out = 0, col_val = 0, win_val = 0, col_x = 0, row_y = 0.
- Reset mid-frame: counters clear immediately, and the next accepted pixel is (0,0). Stale memory contents are hidden by zero-gating.
- Frame wrap and line wrap on the same ena edge: both counters go to 0 together.
- Memories must map to single-port-per-buffer synchronous RAM: one read and one write per buffer per cycle at the same address.

## Configuration
- PWIN_FRAME_SYNC_EN defined:
  - adds input sof (1 bit); ena and sof together force the pixel to position (0,0);
  - zero-gating restarts and the counters then continue from (1,0);
  - sof without ena is ignored.
- Undefined: the sof port is absent, and frame alignment depends only on counting from reset.

## Test plan
All scenarios use IMG_W=8, IMG_H=4, ROWS=3, WIDTH=8 unless stated otherwise.
- Reset then first pixel: dat_in=0x11 -> next cycle col_val=1, col_out={0x00,0x00,0x11}, col_x=0, row_y=0, win_val=0.
- Continuous ramp, pixel value = 8y+x: at input (x=2,y=2) -> col_out={0x02,0x0A,0x12}, win_val=1. At (1,2) -> win_val=0.
- ena gaps: toggle ena every other cycle -> col_val pulses only after enabled cycles, outputs hold in between, and column content is identical to the continuous case.
- Frame wrap: stream 32 pixels, then pixel 0x55 -> col_x=0, row_y=0, col_out={0x00,0x00,0x55}; old-frame data does not appear.
- Async reset at (5,1) mid-stream, then resume -> outputs 0 during reset, and the first pixel after release reports (0,0) with upper slices zero.
- With PWIN_FRAME_SYNC_EN: sof+ena at counter position (3,2) -> that pixel reports col_x=0, row_y=0, and the next pixel reports col_x=1.

Source files
------------

// File: rtl/pixel_window_col.sv
// Raster pixel stream to vertical ROWS-pixel column, using ROWS-1 circular line memories.
// Define PWIN_FRAME_SYNC_EN to add the sof input (frame restart on sof & ena).
module pixel_window_col #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int ROWS  = 7,
  parameter int CW    = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
`ifdef PWIN_FRAME_SYNC_EN
  input  logic                  sof,
`endif
  input  logic [WIDTH-1:0]      dat_in,
  output logic [ROWS*WIDTH-1:0] col_out,
  output logic                  col_val,
  output logic                  win_val,
  output logic [CW-1:0]         col_x,
  output logic [CW-1:0]         row_y
);

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CW-1:0] X_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(IMG_H - 1);
  localparam logic [CW-1:0] EDGE   = CW'(ROWS - 1);

  logic [CW-1:0] x_cnt_reg, y_cnt_reg;
  logic [CW-1:0] x_cnt_next, y_cnt_next;
  logic [CW-1:0] x_cur, y_cur;
  logic          frame_restart;
  logic [AW-1:0] addr;

`ifdef PWIN_FRAME_SYNC_EN
  assign frame_restart = ena & sof;
`else
  assign frame_restart = 1'b0;
`endif

  // Position of the pixel being accepted; a frame restart relabels it (0,0).
  assign x_cur = frame_restart ? '0 : x_cnt_reg;
  assign y_cur = frame_restart ? '0 : y_cnt_reg;
  assign addr  = x_cur[AW-1:0];

  always_comb begin
    x_cnt_next = x_cnt_reg;
    y_cnt_next = y_cnt_reg;
    if (ena) begin
      if (x_cur == X_LAST) begin
        x_cnt_next = '0;
        y_cnt_next = (y_cur == Y_LAST) ? '0 : y_cur + 1'b1;
      end else begin
        x_cnt_next = x_cur + 1'b1;
        y_cnt_next = y_cur;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt_reg <= '0;
      y_cnt_reg <= '0;
    end else begin
      x_cnt_reg <= x_cnt_next;
      y_cnt_reg <= y_cnt_next;
    end
  end

  // Line memories: buffer k holds line y-k; each one shifts its old word into buffer k+1.
  logic [WIDTH-1:0] rd_all [1:ROWS-1];

  for (genvar gi = 1; gi < ROWS; gi++) begin : g_lbuf
    logic [WIDTH-1:0] mem [0:IMG_W-1];
    logic [WIDTH-1:0] wr_data;

    if (gi == 1) begin : g_head
      assign wr_data = dat_in;
    end else begin : g_tail
      assign wr_data = rd_all[gi-1];
    end

    assign rd_all[gi] = mem[addr];

    always_ff @(posedge clk) begin
      if (ena) begin
        mem[addr] <= wr_data;
      end
    end
  end

  logic [ROWS-1:0][WIDTH-1:0] col_reg;
  logic                       col_val_reg, win_val_reg;
  logic [CW-1:0]              col_x_reg, row_y_reg;

  // Lines above the top of the current frame read as zero, so memory needs no reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_reg     <= '0;
      col_val_reg <= 1'b0;
      win_val_reg <= 1'b0;
      col_x_reg   <= '0;
      row_y_reg   <= '0;
    end else begin
      col_val_reg <= ena;
      win_val_reg <= ena && (y_cur >= EDGE) && (x_cur >= EDGE);
      if (ena) begin
        col_reg[0] <= dat_in;
        for (int k = 1; k < ROWS; k++) begin
          col_reg[k] <= (y_cur >= CW'(k)) ? rd_all[k] : '0;
        end
        col_x_reg <= x_cur;
        row_y_reg <= y_cur;
      end
    end
  end

  assign col_out = col_reg;
  assign col_val = col_val_reg;
  assign win_val = win_val_reg;
  assign col_x   = col_x_reg;
  assign row_y   = row_y_reg;

endmodule
